// File: rtl/bnn_infer_seq.sv
// Frame sequencer for a binary neural network: collects an image over UART, launches one
// XNOR/popcount evaluation per output neuron, and reports the arg-max class as an ASCII digit.
module bnn_infer_seq #(
    parameter int N_BYTES   = 8,
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 7,
    parameter int TIMEOUT   = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   uart_cts,
    output logic [8*N_BYTES-1:0]   image,
    output logic                   mac_start,
    output logic [3:0]             mac_idx,
    input  logic                   mac_done,
    input  logic [SCORE_W-1:0]     mac_score,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   overrun,
    output logic                   busy
);

    localparam int BCNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC_REQ,
        MAC_WAIT,
        SEND
    } state_t;

    state_t              state;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [TCNT_W-1:0]   idle_cnt;
    logic [SCORE_W-1:0]  best_score;
    logic [3:0]          best_idx;
    logic                take_new;
    logic [3:0]          win_idx;

    // Winner including the score arriving this cycle; strict compare keeps the lower index on ties.
    always_comb begin
        take_new = (mac_idx == 4'd0) || (mac_score > best_score);
        win_idx  = take_new ? mac_idx : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            uart_cts   <= 1'b1;
            busy       <= 1'b0;
            mac_start  <= 1'b0;
            mac_idx    <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            overrun    <= 1'b0;
            image      <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            best_score <= '0;
            best_idx   <= '0;
        end else begin
            if (rx_valid && !uart_cts)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == 8'hA5) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                        overrun  <= 1'b0;
                    end
                end

                LOAD: begin
                    if (rx_valid) begin
                        image[8*byte_cnt +: 8] <= rx_data;
                        idle_cnt <= '0;
                        if (byte_cnt == BCNT_W'(N_BYTES - 1)) begin
                            state     <= MAC_REQ;
                            uart_cts  <= 1'b0;
                            mac_start <= 1'b1;
                            mac_idx   <= '0;
                            byte_cnt  <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (idle_cnt == TCNT_W'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                MAC_REQ: begin
                    mac_start <= 1'b0;
                    state     <= MAC_WAIT;
                end

                MAC_WAIT: begin
                    if (mac_done) begin
                        if (take_new)
                            best_score <= mac_score;
                        best_idx <= win_idx;
                        if (mac_idx == 4'(N_CLASSES - 1)) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= 8'h30 + {4'h0, win_idx};
                        end else begin
                            mac_idx   <= mac_idx + 1'b1;
                            mac_start <= 1'b1;
                            state     <= MAC_REQ;
                        end
                    end
                end

                SEND: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        uart_cts <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    uart_cts <= 1'b1;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_infer_seq.sv
// Directed bench for bnn_infer_seq: transaction-level model of frame/phase/overrun/arg-max,
// a per-cycle compare process, and a latency-3 neuron datapath responder.
module tb_bnn_infer_seq;

    localparam int NB  = 8;
    localparam int NC  = 10;
    localparam int SW  = 7;
    localparam int TO  = 40;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          uart_cts;
    logic [8*NB-1:0] image;
    logic          mac_start;
    logic [3:0]    mac_idx;
    logic          mac_done = 1'b0;
    logic [SW-1:0] mac_score = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          overrun;
    logic          busy;

    bnn_infer_seq #(.N_BYTES(NB), .N_CLASSES(NC), .SCORE_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .uart_cts(uart_cts), .image(image), .mac_start(mac_start), .mac_idx(mac_idx),
        .mac_done(mac_done), .mac_score(mac_score), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = waiting for sync, 1 = collecting image, 2 = computing/sending
    int            m_phase = 0;
    int            m_cnt = 0;
    int            m_idle = 0;
    logic [63:0]   m_image = '0;
    logic          m_overrun = 1'b0;
    int            score_tbl [NC];
    int            idx_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_digit();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if (score_tbl[i] > score_tbl[best]) best = i;
        return 8'h30 + 8'(best);
    endfunction

    // Consumed at the next rising edge; returns at that edge + 1.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        case (m_phase)
            0: if (b == 8'hA5) begin
                   m_phase = 1; m_cnt = 0; m_idle = 0; m_overrun = 1'b0;
               end
            1: begin
                   m_image[8*m_cnt +: 8] = b;
                   m_cnt++;
                   m_idle = 0;
                   if (m_cnt == NB) m_phase = 2;
               end
            default: m_overrun = 1'b1;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (m_phase == 1) begin
                m_idle++;
                if (m_idle == TO) m_phase = 0;
            end
        end
    endtask

    task automatic send_frame();
        send_byte(8'hA5);
        for (int i = 1; i <= NB; i++) send_byte(8'(i));
    endtask

    task automatic wait_tx();
        int n = 0;
        while (!tx_valid && n < 1000) begin
            idle_cycles(1);
            n++;
        end
        chk("tx_valid_timeout", 64'(tx_valid), 64'd1);
    endtask

    task automatic handshake();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        m_phase = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_phase = 0; m_image = '0; m_overrun = 1'b0; m_cnt = 0; m_idle = 0;
    endtask

    task automatic chk_sweep();
        tests++;
        if (idx_log.size() != NC) begin
            fails++;
            $display("FAIL mac_sweep_len: got %0d starts, expected %0d", idx_log.size(), NC);
        end else begin
            for (int i = 0; i < NC; i++)
                if (idx_log[i] != i) begin
                    fails++;
                    $display("FAIL mac_sweep_idx: position %0d got %0d, expected %0d", i, idx_log[i], i);
                    break;
                end
        end
        idx_log.delete();
    endtask

    // Neuron datapath: fixed latency, score taken from the table.
    initial begin
        forever begin
            @(negedge clk);
            if (mac_start) begin
                automatic int idx = int'(mac_idx);
                idx_log.push_back(idx);
                repeat (LAT) @(posedge clk);
                #1;
                mac_score = SW'(score_tbl[idx]);
                mac_done  = 1'b1;
                tests++;
                if (int'(mac_idx) != idx) begin
                    fails++;
                    $display("FAIL mac_idx_stable: got %0d, expected %0d", mac_idx, idx);
                end
                @(posedge clk); #1;
                mac_done = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    logic       prev_tv = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_ms = 1'b0;
    logic [7:0] prev_td = '0;
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("uart_cts", 64'(uart_cts), 64'(m_phase != 2));
            chk("image", image, m_image);
            chk("overrun", 64'(overrun), 64'(m_overrun));
            if (m_phase != 2) chk("tx_valid_outside_frame", 64'(tx_valid), 64'd0);
            if (m_phase != 2) chk("mac_start_outside_frame", 64'(mac_start), 64'd0);
            if (tx_valid) chk("tx_data", 64'(tx_data), 64'(exp_digit()));
            if (prev_tv && !prev_ready && !prev_rst) begin
                chk("tx_valid_hold", 64'(tx_valid), 64'd1);
                chk("tx_data_hold", 64'(tx_data), 64'(prev_td));
            end
            if (prev_ms) chk("mac_start_single", 64'(mac_start), 64'd0);
            prev_tv = tx_valid; prev_td = tx_data; prev_ready = tx_ready;
            prev_rst = rst; prev_ms = mac_start;
        end
    end

    initial begin
        for (int i = 0; i < NC; i++) score_tbl[i] = 3 * i;
        @(posedge clk); #1;
        do_reset();
        chk("rst_tx_data", 64'(tx_data), 64'h00);
        chk("rst_mac_idx", 64'(mac_idx), 64'd0);
        chk("rst_image", image, 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);

        // Non-sync byte is discarded, then sync starts a frame.
        send_byte(8'h5A);
        chk("ignore_5a_busy", 64'(busy), 64'd0);
        send_byte(8'hA5);
        chk("a5_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= NB; i++) send_byte(8'(i));
        chk("image_literal", image, 64'h0807060504030201);
        wait_tx();
        chk("ramp_digit_literal", 64'(tx_data), 64'h39);
        chk_sweep();
        handshake();
        idle_cycles(1);
        chk("after_tx_valid", 64'(tx_valid), 64'd0);
        chk("after_busy", 64'(busy), 64'd0);

        // All scores equal: lowest index wins.
        for (int i = 0; i < NC; i++) score_tbl[i] = 20;
        send_frame();
        wait_tx();
        chk("tie_digit_literal", 64'(tx_data), 64'h30);
        chk_sweep();
        handshake();

        // Mixed scores with a late tie against the best (index 4 keeps).
        for (int i = 0; i < NC; i++) score_tbl[i] = 5;
        score_tbl[4] = 100; score_tbl[7] = 100; score_tbl[9] = 99;
        send_frame();
        wait_tx();
        chk("mixed_digit_literal", 64'(tx_data), 64'h34);
        chk_sweep();
        handshake();

        // Partial frame then timeout: no computation, image keeps partial bytes.
        send_byte(8'hA5);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        idle_cycles(TO - 1);
        chk("timeout_still_loading", 64'(busy), 64'd1);
        idle_cycles(1);
        chk("timeout_idle", 64'(busy), 64'd0);
        chk("timeout_image_literal", image, 64'h0807060504C3C2C1);
        idle_cycles(5);
        chk("timeout_no_mac", 64'(idx_log.size()), 64'd0);

        // Byte on the cycle the idle count would expire is accepted.
        for (int i = 0; i < NC; i++) score_tbl[i] = (i == 2) ? 50 : 10;
        send_byte(8'hA5);
        send_byte(8'h11);
        idle_cycles(TO - 1);
        send_byte(8'h22);
        chk("boundary_accepted", 64'(busy), 64'd1);
        for (int i = 3; i <= NB; i++) send_byte(8'(i));
        // Stray byte while computing sets overrun and leaves the image alone.
        idle_cycles(3);
        send_byte(8'hFF);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overrun_image_literal", image, 64'h0807060504032211);
        wait_tx();
        chk("boundary_digit_literal", 64'(tx_data), 64'h32);
        chk_sweep();
        handshake();
        send_byte(8'hA5);
        chk("overrun_cleared", 64'(overrun), 64'd0);
        for (int i = 1; i <= NB; i++) send_byte(8'(i));
        wait_tx();
        chk_sweep();

        // Hold tx_ready low, then abort with reset mid-send.
        idle_cycles(50);
        chk("hold_tx_valid", 64'(tx_valid), 64'd1);
        chk("hold_tx_data", 64'(tx_data), 64'h32);
        do_reset();
        chk("abort_tx_valid", 64'(tx_valid), 64'd0);
        chk("abort_cts", 64'(uart_cts), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bnn_infer_seq.md
BNN_INFER_SEQ -- requirements
Module: bnn_infer_seq

Interface
REQ-001 SHALL have parameter N_BYTES, default 8: image bytes per frame; image width = 8*N_BYTES bits.
REQ-002 SHALL have parameter N_CLASSES, default 10: output neurons evaluated per frame; legal range 1..10.
REQ-003 SHALL have parameter SCORE_W, default 7: popcount score width.
REQ-004 SHALL have parameter TIMEOUT, default 1000: idle clocks allowed between bytes in LOAD.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-007 SHALL have port rx_data  input  8: byte from UART receiver.
REQ-008 SHALL have port rx_valid  input  1: one-cycle strobe; rx_data valid.
REQ-009 SHALL have port uart_cts  output  1: high = sequencer accepts bytes.
REQ-010 SHALL have port image  output  8*N_BYTES: frame image register feeding the XNOR datapath.
REQ-011 SHALL have port mac_start  output  1: one-cycle pulse launching one neuron evaluation.
REQ-012 SHALL have port mac_idx  output  4: neuron index; stable from mac_start through mac_done.
REQ-013 SHALL have port mac_done  input  1: one-cycle strobe; mac_score valid.
REQ-014 SHALL have port mac_score  input  SCORE_W: unsigned popcount for neuron mac_idx.
REQ-015 SHALL have port tx_data  output  8: result byte to UART transmitter.
REQ-016 SHALL have port tx_valid  output  1: result byte pending.
REQ-017 SHALL have port tx_ready  input  1: byte transfers on cycle with tx_valid&tx_ready.
REQ-018 SHALL have port overrun  output  1: sticky; byte arrived while uart_cts low.
REQ-019 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-020 FSM SHALL have states IDLE, LOAD, MAC_REQ, MAC_WAIT, SEND.
REQ-021 IDLE: uart_cts=1; rx_valid with rx_data==0xA5 -> LOAD, byte count=0, idle count=0, overrun cleared; any other byte discarded, stay IDLE.
REQ-022 LOAD: uart_cts=1; each rx_valid writes rx_data to image[8k+7:8k] (k = byte count), k+1; 0xA5 not special; after byte N_BYTES-1 -> MAC_REQ, mac_idx=0.
REQ-023 LOAD timeout: idle count clears on each accepted byte, else +1; reaching TIMEOUT -> IDLE, no computation, no TX; image keeps partial content.
REQ-024 rx_valid in the same cycle the idle count would reach TIMEOUT: byte accepted, no timeout.
REQ-025 MAC_REQ: mac_start=1 for exactly one cycle, then -> MAC_WAIT.
REQ-026 MAC_WAIT: on mac_done, if mac_idx==0 or mac_score > best_score (strict unsigned), load best_score=mac_score, best_idx=mac_idx; ties keep lower index.
REQ-027 MAC_WAIT on mac_done: if mac_idx==N_CLASSES-1 -> SEND, else mac_idx+1 -> MAC_REQ; per-neuron cost = 2 cycles + datapath latency.
REQ-028 mac_done outside MAC_WAIT SHALL be ignored.
REQ-029 SEND: tx_valid=1, tx_data=0x30+best_idx (ASCII digit), both stable until tx_valid&tx_ready; on that cycle -> IDLE; tx_valid low the next cycle.
REQ-030 uart_cts=0 in MAC_REQ, MAC_WAIT, SEND; rx_valid there: byte dropped, image unchanged, overrun=1.
REQ-031 image SHALL change only in LOAD; stable throughout MAC_REQ, MAC_WAIT, SEND.

Reset
REQ-032 rst high at a rising edge SHALL set: state=IDLE, uart_cts=1, busy=0, mac_start=0, mac_idx=0, tx_valid=0, tx_data=0x00, overrun=0, image=0, all counters=0, best_score=0, best_idx=0.
REQ-033 rst SHALL override all inputs in the same cycle; in any state, including mid-LOAD or SEND with tx_valid high, the frame is aborted with no partial TX.

Verification
REQ-034 0xA5 then 0x01..0x08; model returns score 3*i for neuron i -> mac_idx sweeps 0..9, one mac_start each; tx_data=0x39, handshake completes, busy=0.
REQ-035 Same frame, every score = 20 -> tx_data=0x30 (tie keeps index 0).
REQ-036 Byte 0x5A in IDLE -> ignored, busy stays 0; then 0xA5 -> busy=1 next cycle.
REQ-037 0xA5 + 3 bytes, then TIMEOUT idle cycles -> IDLE, mac_start never pulses, tx_valid never asserted.
REQ-038 rx_valid=1 with rx_data=0xFF during MAC_WAIT -> overrun=1, image unchanged; next 0xA5 in IDLE clears overrun.
REQ-039 tx_ready held low 50 cycles in SEND -> tx_valid/tx_data stable; rst pulse mid-SEND -> tx_valid=0, uart_cts=1, state IDLE next cycle.
